ttl_out_sequencer: RTL and testbench

- Sits directly downstream of the RTOB core in the TTLx8 output path.
- Consumes the 128-bit word the core presents with its one-cycle counter_matched strobe, and drives the 8 TTL output lines.
- Per channel, each command either sets a level or fires a timed pulse that reverts automatically after a programmed number of clock cycles.
- Reports command overrides of in-flight pulses and counts executed commands.

---
 rtl/ttl_out_pkg.sv | 21 ++
 rtl/ttl_out_channel.sv | 82 ++++++++
 rtl/ttl_out_sequencer.sv | 95 +++++++++
 tb/tb_ttl_out_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_out_pkg.sv
// Shared field positions and channel state type for the TTL output sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ttl_out_pkg;

   // Bit positions of the fields in the 128-bit command word
   localparam int TS_HI    = 127;
   localparam int TS_LO    = 64;
   localparam int PLEN_HI  = 63;
   localparam int PLEN_LO  = 32;
   localparam int PEN_LO   = 16;
   localparam int WMASK_LO = 8;
   localparam int VAL_LO   = 0;

   // Per-channel state: steady level, or a timed pulse counting down
   typedef enum logic {
      CH_IDLE  = 1'b0,
      CH_PULSE = 1'b1
   } ch_state_t;

endpackage

// File: rtl/ttl_out_channel.sv
// One TTL channel: level/pulse FSM, pulse-length down-counter and output flop.
// Latency: a write shows on ttl one cycle after it is presented; pulses revert after pulse_len cycles.
// Backpressure: none; every write is taken immediately and replaces any pulse in flight.
module ttl_out_channel
   import ttl_out_pkg::*;
#(
   parameter int   CNT_W    = 32,
   parameter logic INIT_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             wr,
   input  logic             value,
   input  logic             pulse_en,
   input  logic [CNT_W-1:0] pulse_len,
   output logic             ttl,
   output logic             busy,
   output logic             override
);

   ch_state_t        state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             ttl_q, ttl_d;
   logic             val_lat_q, val_lat_d;
   logic             last_cycle;

   // rem==1 means the pulse ends on this edge; a write landing here is not an override
   assign last_cycle = (rem_q == CNT_W'(1));

   // Register the channel state, counter, latched pulse value and output level
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= CH_IDLE;
         rem_q     <= '0;
         ttl_q     <= INIT_BIT;
         val_lat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         ttl_q     <= ttl_d;
         val_lat_q <= val_lat_d;
      end
   end

   // Next state: flush beats a write, a write beats the running pulse
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      ttl_d     = ttl_q;
      val_lat_d = val_lat_q;
      override  = 1'b0;
      if (flush) begin
         state_d = CH_IDLE;
         rem_d   = '0;
         ttl_d   = INIT_BIT;
      end else if (wr) begin
         ttl_d    = value;
         override = (state_q == CH_PULSE) && !last_cycle;
         if (pulse_en && (pulse_len != '0)) begin
            state_d   = CH_PULSE;
            rem_d     = pulse_len;
            val_lat_d = value;
         end else begin
            state_d = CH_IDLE;
            rem_d   = '0;
         end
      end else if (state_q == CH_PULSE) begin
         if (last_cycle) begin
            state_d = CH_IDLE;
            rem_d   = '0;
            ttl_d   = ~val_lat_q;
         end else begin
            rem_d = rem_q - CNT_W'(1);
         end
      end
   end

   assign ttl  = ttl_q;
   assign busy = (state_q == CH_PULSE);

endmodule

// File: rtl/ttl_out_sequencer.sv
// TTL output sequencer: decodes RTOB command words into per-channel level sets and timed pulses.
// Latency: one cycle from counter_matched to ttl_out; all outputs registered.
// Backpressure: none; every strobe outside flush/reset is executed and counted.
module ttl_out_sequencer
   import ttl_out_pkg::*;
#(
   parameter int         NUM_CH     = 8,
   parameter int         CNT_W      = 32,
   parameter logic [7:0] INIT_VALUE = 8'h00
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              counter_matched,
   input  logic [127:0]      rto_in,
   input  logic              err_clear,
   output logic [NUM_CH-1:0] ttl_out,
   output logic [NUM_CH-1:0] busy,
   output logic              override_err,
   output logic [NUM_CH-1:0] override_ch,
   output logic [CNT_W-1:0]  cmd_count
);

   logic              strobe_ok;
   logic [CNT_W-1:0]  plen;
   logic [NUM_CH-1:0] wmask;
   logic [NUM_CH-1:0] pen;
   logic [NUM_CH-1:0] val;
   logic [NUM_CH-1:0] ovr;
   logic              unused_bits;

   // Flush drops a coincident command, so it is neither executed nor counted
   assign strobe_ok = counter_matched && !flush;

   assign wmask = rto_in[WMASK_LO +: NUM_CH];
   assign pen   = rto_in[PEN_LO   +: NUM_CH];
   assign val   = rto_in[VAL_LO   +: NUM_CH];

   // Timestamp, reserved bits and channels beyond NUM_CH carry nothing for us
   assign unused_bits = ^{rto_in[TS_HI:TS_LO], rto_in};

   // Fit the 32-bit pulse length field to the counter width
   generate
      if (CNT_W <= 32) begin : g_plen_trunc
         assign plen = rto_in[PLEN_LO +: CNT_W];
      end else begin : g_plen_ext
         assign plen = {{(CNT_W-32){1'b0}}, rto_in[PLEN_HI:PLEN_LO]};
      end
   endgenerate

   // One independent channel per TTL line
   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         ttl_out_channel #(
            .CNT_W    (CNT_W),
            .INIT_BIT (INIT_VALUE[i])
         ) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .flush     (flush),
            .wr        (strobe_ok && wmask[i]),
            .value     (val[i]),
            .pulse_en  (pen[i]),
            .pulse_len (plen),
            .ttl       (ttl_out[i]),
            .busy      (busy[i]),
            .override  (ovr[i])
         );
      end
   endgenerate

   // Count every accepted strobe, wrapping naturally at the counter width
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_count <= '0;
      end else if (strobe_ok) begin
         cmd_count <= cmd_count + CNT_W'(1);
      end
   end

   // Sticky override flags; a fresh override in the clearing cycle survives the clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         override_err <= 1'b0;
         override_ch  <= '0;
      end else if (err_clear) begin
         override_err <= |ovr;
         override_ch  <= ovr;
      end else begin
         override_err <= override_err || (|ovr);
         override_ch  <= override_ch | ovr;
      end
   end

endmodule

// File: tb/tb_ttl_out_sequencer.sv
module tb_ttl_out_sequencer;

   logic         clk = 1'b0;
   logic         resetn;
   logic         flush;
   logic         cm;
   logic [127:0] rto;
   logic         ec;
   logic [7:0]   ttl;
   logic [7:0]   busy;
   logic         oerr;
   logic [7:0]   och;
   logic [31:0]  cnt;

   // Narrow-counter instance used only for the wrap check
   logic         w_flush;
   logic         w_cm;
   logic [127:0] w_rto;
   logic         w_ec;
   logic [7:0]   w_ttl;
   logic [7:0]   w_busy;
   logic         w_oerr;
   logic [7:0]   w_och;
   logic [3:0]   w_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ttl_out_sequencer #(.NUM_CH(8), .CNT_W(32), .INIT_VALUE(8'h00)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .counter_matched(cm),
      .rto_in(rto), .err_clear(ec), .ttl_out(ttl), .busy(busy),
      .override_err(oerr), .override_ch(och), .cmd_count(cnt)
   );

   ttl_out_sequencer #(.NUM_CH(8), .CNT_W(4), .INIT_VALUE(8'h00)) u_wrap (
      .clk(clk), .resetn(resetn), .flush(w_flush), .counter_matched(w_cm),
      .rto_in(w_rto), .err_clear(w_ec), .ttl_out(w_ttl), .busy(w_busy),
      .override_err(w_oerr), .override_ch(w_och), .cmd_count(w_cnt)
   );

   typedef struct packed {
      logic         fl;
      logic         cm;
      logic [127:0] rto;
      logic         ec;
      logic [7:0]   e_ttl;
      logic [7:0]   e_busy;
      logic         e_err;
      logic [31:0]  e_cnt;
   } vec_t;

   vec_t vt [16];

   function automatic logic [127:0] mk(input logic [31:0] len, input logic [7:0] pen,
                                       input logic [7:0] wr, input logic [7:0] v);
      return {64'hDEAD_BEEF_0BAD_F00D, len, 8'h00, pen, wr, v};
   endfunction

   function automatic vec_t mkv(input logic fl, input logic c, input logic [127:0] r,
                                input logic e, input logic [7:0] et, input logic [7:0] eb,
                                input logic ee, input logic [31:0] ecnt);
      vec_t x;
      x.fl = fl; x.cm = c; x.rto = r; x.ec = e;
      x.e_ttl = et; x.e_busy = eb; x.e_err = ee; x.e_cnt = ecnt;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for exactly one edge
   task automatic strobe(input logic [127:0] r);
      cm  = 1'b1;
      rto = r;
      tick();
      cm  = 1'b0;
      rto = '0;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; cm = 1'b0; rto = '0; ec = 1'b0;
      w_flush = 1'b0; w_cm = 1'b0; w_rto = '0; w_ec = 1'b0;

      //        fl    cm    rto                              ec    ttl    busy   err  cnt
      vt[0]  = mkv(1'b0, 1'b0, '0,                            1'b0, 8'h00, 8'h00, 1'b0, 0);
      vt[1]  = mkv(1'b0, 1'b1, mk(0, 8'h00, 8'hFF, 8'hA5),    1'b0, 8'hA5, 8'h00, 1'b0, 1);
      vt[2]  = mkv(1'b0, 1'b1, mk(3, 8'h01, 8'h01, 8'h01),    1'b0, 8'hA5, 8'h01, 1'b0, 2);
      vt[3]  = mkv(1'b0, 1'b0, '0,                            1'b0, 8'hA5, 8'h01, 1'b0, 2);
      vt[4]  = mkv(1'b0, 1'b0, '0,                            1'b0, 8'hA5, 8'h01, 1'b0, 2);
      vt[5]  = mkv(1'b0, 1'b0, '0,                            1'b0, 8'hA4, 8'h00, 1'b0, 2);
      vt[6]  = mkv(1'b0, 1'b0, '0,                            1'b0, 8'hA4, 8'h00, 1'b0, 2);
      vt[7]  = mkv(1'b0, 1'b1, mk(0, 8'h00, 8'h00, 8'hFF),    1'b0, 8'hA4, 8'h00, 1'b0, 3);
      vt[8]  = mkv(1'b0, 1'b1, mk(0, 8'h00, 8'hF0, 8'h0F),    1'b0, 8'h04, 8'h00, 1'b0, 4);
      vt[9]  = mkv(1'b0, 1'b1, mk(2, 8'h0F, 8'h0F, 8'h0A),    1'b0, 8'h0A, 8'h0F, 1'b0, 5);
      vt[10] = mkv(1'b0, 1'b0, '0,                            1'b0, 8'h0A, 8'h0F, 1'b0, 5);
      vt[11] = mkv(1'b0, 1'b0, '0,                            1'b0, 8'h05, 8'h00, 1'b0, 5);
      vt[12] = mkv(1'b0, 1'b1, mk(0, 8'h80, 8'h80, 8'h80),    1'b0, 8'h85, 8'h00, 1'b0, 6);
      vt[13] = mkv(1'b1, 1'b0, '0,                            1'b0, 8'h00, 8'h00, 1'b0, 6);
      vt[14] = mkv(1'b1, 1'b1, mk(5, 8'hFF, 8'hFF, 8'hFF),    1'b0, 8'h00, 8'h00, 1'b0, 6);
      vt[15] = mkv(1'b0, 1'b0, '0,                            1'b1, 8'h00, 8'h00, 1'b0, 6);

      tick();
      tick();
      resetn = 1'b1;
      chk("reset_och", 64'(och), 64'h0);

      // Level sets, short pulses, masked writes, flush: one edge per row
      for (int i = 0; i < 16; i++) begin
         flush = vt[i].fl; cm = vt[i].cm; rto = vt[i].rto; ec = vt[i].ec;
         tick();
         flush = 1'b0; cm = 1'b0; rto = '0; ec = 1'b0;
         chk($sformatf("vec%0d_ttl", i),  64'(ttl),  64'(vt[i].e_ttl));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
         chk($sformatf("vec%0d_err", i),  64'(oerr), 64'(vt[i].e_err));
         chk($sformatf("vec%0d_cnt", i),  64'(cnt),  64'(vt[i].e_cnt));
      end

      // Override of a 10-cycle pulse on ch2 while rem=5
      strobe(mk(10, 8'h04, 8'h04, 8'h04));
      for (int k = 0; k < 5; k++) tick();
      chk("ovr_pre_busy", 64'(busy), 64'h04);
      chk("ovr_pre_ttl",  64'(ttl),  64'h04);
      strobe(mk(0, 8'h00, 8'h04, 8'h00));
      chk("ovr_ttl",  64'(ttl),  64'h00);
      chk("ovr_busy", 64'(busy), 64'h00);
      chk("ovr_err",  64'(oerr), 64'h1);
      chk("ovr_ch",   64'(och),  64'h04);
      ec = 1'b1; tick(); ec = 1'b0;
      chk("clr_err", 64'(oerr), 64'h0);
      chk("clr_ch",  64'(och),  64'h00);

      // Write landing exactly on rem=1: new command wins, no error
      strobe(mk(10, 8'h04, 8'h04, 8'h04));
      for (int k = 0; k < 9; k++) tick();
      strobe(mk(0, 8'h00, 8'h04, 8'h04));
      chk("rem1_ttl",  64'(ttl),  64'h04);
      chk("rem1_busy", 64'(busy), 64'h00);
      chk("rem1_err",  64'(oerr), 64'h0);
      chk("rem1_cnt",  64'(cnt),  64'd10);

      // Clear coinciding with a new override: set wins, only new channel shown
      strobe(mk(10, 8'h24, 8'h24, 8'h24));
      tick();
      strobe(mk(0, 8'h00, 8'h04, 8'h00));
      chk("ovr2_ch", 64'(och), 64'h04);
      tick();
      ec = 1'b1;
      strobe(mk(0, 8'h00, 8'h20, 8'h00));
      ec = 1'b0;
      chk("clrset_err", 64'(oerr), 64'h1);
      chk("clrset_ch",  64'(och),  64'h20);
      chk("clrset_cnt", 64'(cnt),  64'd13);

      // Maximum pulse length loads without truncation
      strobe(mk(32'hFFFF_FFFF, 8'h08, 8'h08, 8'h08));
      for (int k = 1; k <= 100; k++) begin
         if (k % 20 == 0) begin
            chk($sformatf("long%0d_busy", k), 64'(busy), 64'h08);
            chk($sformatf("long%0d_ttl", k),  64'(ttl),  64'h08);
         end
         tick();
      end
      flush = 1'b1; tick(); flush = 1'b0;
      chk("long_flush_ttl",  64'(ttl),  64'h00);
      chk("long_flush_busy", 64'(busy), 64'h00);
      chk("long_flush_cnt",  64'(cnt),  64'd14);
      chk("long_flush_och",  64'(och),  64'h20);

      // Flush with a coincident strobe while a pulse is in flight
      strobe(mk(20, 8'h02, 8'h02, 8'h02));
      tick();
      chk("fs_pre_busy", 64'(busy), 64'h02);
      flush = 1'b1;
      strobe(mk(4, 8'hFF, 8'hFF, 8'hFF));
      flush = 1'b0;
      chk("fs_ttl",  64'(ttl),  64'h00);
      chk("fs_busy", 64'(busy), 64'h00);
      chk("fs_cnt",  64'(cnt),  64'd15);
      chk("fs_err",  64'(oerr), 64'h1);
      chk("fs_och",  64'(och),  64'h20);

      // Asynchronous reset mid-pulse; value 0 so a late revert would show as a 1
      strobe(mk(50, 8'h40, 8'h40, 8'h00));
      tick(); tick();
      chk("rst_pre_busy", 64'(busy), 64'h40);
      #2 resetn = 1'b0;
      #1;
      chk("rst_ttl",  64'(ttl),  64'h00);
      chk("rst_busy", 64'(busy), 64'h00);
      chk("rst_err",  64'(oerr), 64'h0);
      chk("rst_och",  64'(och),  64'h00);
      chk("rst_cnt",  64'(cnt),  64'h0);
      strobe(mk(0, 8'h00, 8'hFF, 8'hFF));
      resetn = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k % 10 == 0) begin
            chk($sformatf("post_rst%0d_ttl", k),  64'(ttl),  64'h00);
            chk($sformatf("post_rst%0d_busy", k), 64'(busy), 64'h00);
         end
      end
      chk("post_rst_cnt", 64'(cnt), 64'h0);

      // Counter wrap on the 4-bit instance
      for (int k = 0; k < 15; k++) begin
         w_cm = 1'b1; w_rto = mk(0, 8'h00, 8'h00, 8'h00);
         tick();
      end
      w_cm = 1'b0;
      chk("wrap_full", 64'(w_cnt), 64'hF);
      w_cm = 1'b1; tick(); w_cm = 1'b0;
      chk("wrap_zero", 64'(w_cnt), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
